spi_slave_frame: RTL and testbench

- Parametrised next-generation SPI slave bridging a serial master to the synchronous RAM command/data interface.
- SPI bit timing equals `clk`: one MOSI bit is sampled per `clk` while `SS_n` is low.
- Adds to the previous slave:
  - configurable data width and bit order;
  - `rx_data` that is stable except on word completion;
  - an explicit wait for `tx_valid` before read data is shifted out on MISO;
  - a frame-abort error flag and a `busy` indication.

---
 rtl/spi_slave_frame.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_frame
// Summary  : SPI slave framing a serial master onto a RAM command/data port.
//            One MOSI bit per clk while SS_n is low. A selector bit picks
//            write or read. Reads use a two-frame address/data handshake.
//            Read data waits for tx_valid before it is shifted out on MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_frame #(
  parameter int DATA_W    = 8,
  parameter int CMD_W     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      SS_n,
  input  logic                      MOSI,
  output logic                      MISO,
  output logic [CMD_W+DATA_W-1:0]   rx_data,
  output logic                      rx_valid,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TXS_W   = DATA_W - 1;

  // Counter value while the final frame bit is on MOSI.
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
  // Counter value once every read bit has been presented on MISO.
  localparam logic [CNT_W-1:0] TX_END  = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    WAIT_TX   = 3'd5,
    TX        = 3'd6,
    DONE      = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_W-2:0]     rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0]     rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [TXS_W-1:0]       tx_shift_q, tx_shift_d;
  logic                   miso_q, miso_d;
  logic                   addr_pending_q, addr_pending_d;

  // Bit-order dependent views of the shift registers. The receive register
  // only keeps the FRAME_W-1 earlier bits; the live MOSI bit completes the
  // word. The transmit register only keeps the bits not yet on MISO.
  logic [FRAME_W-1:0]     w_rx_word;
  logic [FRAME_W-2:0]     w_rx_keep;
  logic                   w_tx_first;
  logic [TXS_W-1:0]       w_tx_load;
  logic                   w_tx_bit;
  logic [TXS_W-1:0]       w_tx_rest;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_rx_word  = {rx_shift_q, MOSI};
      assign w_rx_keep  = w_rx_word[FRAME_W-2:0];
      assign w_tx_first = tx_data[DATA_W-1];
      assign w_tx_load  = tx_data[DATA_W-2:0];
      assign w_tx_bit   = tx_shift_q[TXS_W-1];
      assign w_tx_rest  = tx_shift_q << 1;
    end else begin : g_lsb_first
      assign w_rx_word  = {MOSI, rx_shift_q};
      assign w_rx_keep  = w_rx_word[FRAME_W-1:1];
      assign w_tx_first = tx_data[0];
      assign w_tx_load  = tx_data[DATA_W-1:1];
      assign w_tx_bit   = tx_shift_q[0];
      assign w_tx_rest  = tx_shift_q >> 1;
    end
  endgenerate

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
      addr_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
      tx_shift_q     <= tx_shift_d;
      miso_q         <= miso_d;
      addr_pending_q <= addr_pending_d;
    end
  end

  // Next-state and datapath update; pulses and MISO default low every cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    tx_shift_d     = tx_shift_q;
    miso_d         = 1'b0;
    addr_pending_d = addr_pending_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!SS_n) begin
          state_d = CHK_CMD;
        end
      end

      CHK_CMD: begin
        cnt_d = '0;
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (!MOSI) begin
          state_d = WRITE;
        end else if (addr_pending_q) begin
          state_d = READ_DATA;
        end else begin
          state_d = READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        rx_shift_d = w_rx_keep;
        if (cnt_q == RX_LAST) begin
          // Completion takes priority over a simultaneous SS_n rise.
          rx_data_d  = w_rx_word;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          if (state_q == WRITE) begin
            state_d = DONE;
          end else if (state_q == READ_ADD) begin
            state_d        = DONE;
            addr_pending_d = 1'b1;
          end else begin
            state_d        = WAIT_TX;
            addr_pending_d = 1'b0;
          end
          if (SS_n) begin
            state_d = IDLE;
          end
        end else if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          cnt_d       = '0;
          rx_shift_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_TX: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          cnt_d       = '0;
        end else if (tx_valid) begin
          // First bit goes out right away; the rest wait in tx_shift.
          tx_shift_d = w_tx_load;
          miso_d     = w_tx_first;
          cnt_d      = CNT_W'(1);
          state_d    = TX;
        end
      end

      TX: begin
        if (cnt_q == TX_END) begin
          cnt_d   = '0;
          state_d = DONE;
        end else if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          cnt_d       = '0;
          tx_shift_d  = '0;
        end else begin
          miso_d     = w_tx_bit;
          tx_shift_d = w_tx_rest;
          cnt_d      = cnt_q + 1'b1;
        end
      end

      DONE: begin
        cnt_d = '0;
        if (SS_n) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_frame
// Summary  : Directed bench for spi_slave_frame. Instance a is 8-bit
//            MSB-first, b is 8-bit LSB-first (shares a's stimulus), and c is
//            16-bit MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_n, mosi, tx_valid;
  logic [7:0]  tx_data;
  logic        miso_a, rx_valid_a, frame_err_a, busy_a;
  logic [9:0]  rx_data_a;
  logic        miso_b, rx_valid_b, frame_err_b, busy_b;
  logic [9:0]  rx_data_b;
  logic        ss_n_c, mosi_c, tx_valid_c;
  logic [15:0] tx_data_c;
  logic        miso_c, rx_valid_c, frame_err_c, busy_c;
  logic [17:0] rx_data_c;

  int tests = 0;
  int fails = 0;
  logic [9:0]  held_a, held_b;

  always #5 clk = ~clk;

  spi_slave_frame #(.DATA_W(8), .CMD_W(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_data(tx_data),
    .tx_valid(tx_valid), .frame_err(frame_err_a), .busy(busy_a));

  spi_slave_frame #(.DATA_W(8), .CMD_W(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_data(tx_data),
    .tx_valid(tx_valid), .frame_err(frame_err_b), .busy(busy_b));

  spi_slave_frame #(.DATA_W(16), .CMD_W(2), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n_c), .MOSI(mosi_c), .MISO(miso_c),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .tx_data(tx_data_c),
    .tx_valid(tx_valid_c), .frame_err(frame_err_c), .busy(busy_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full frame on a/b: SS_n low, selector, then 10 bits sent word[9] first.
  task automatic frame_ab(input logic sel, input logic [9:0] word, input logic rise_last,
                          input logic [9:0] exp_a, input logic [9:0] exp_b, input string name);
    int early;
    int noise;
    early = 0;
    noise = 0;
    ss_n = 1'b0; mosi = 1'b0; tick();
    mosi = sel; tick();
    for (int i = 0; i < 10; i++) begin
      mosi = word[9-i];
      if (rise_last && i == 9) ss_n = 1'b1;
      tick();
      if (i < 9) begin
        if (rx_valid_a || rx_valid_b) early++;
        if (rx_data_a !== held_a || rx_data_b !== held_b) early++;
      end
      if (frame_err_a || frame_err_b || miso_a || miso_b) noise++;
    end
    tests++;
    if (rx_valid_a !== 1'b1 || rx_valid_b !== 1'b1) begin
      fails++;
      $display("FAIL %s_rx_valid: got a=%b b=%b want 1", name, rx_valid_a, rx_valid_b);
    end
    tests++;
    if (rx_data_a !== exp_a || rx_data_b !== exp_b) begin
      fails++;
      $display("FAIL %s_rx_data: got a=%h b=%h want a=%h b=%h", name, rx_data_a, rx_data_b, exp_a, exp_b);
    end
    tests++;
    if (early != 0 || noise != 0) begin
      fails++;
      $display("FAIL %s_during_frame: got early=%0d noise=%0d want 0 0", name, early, noise);
    end
    held_a = exp_a;
    held_b = exp_b;
    mosi = 1'b0;
    tick();
    tests++;
    if (rx_valid_a !== 1'b0 || rx_valid_b !== 1'b0 || rx_data_a !== held_a || rx_data_b !== held_b) begin
      fails++;
      $display("FAIL %s_after: got vld=%b%b data=%h/%h want 00 %h/%h", name,
               rx_valid_a, rx_valid_b, rx_data_a, rx_data_b, held_a, held_b);
    end
  endtask

  // Full frame on c: 18 bits, MSB first, so the expected word is the one sent.
  task automatic frame_c(input logic sel, input logic [17:0] word, input string name);
    int noise;
    noise = 0;
    ss_n_c = 1'b0; mosi_c = 1'b0; tick();
    mosi_c = sel; tick();
    for (int i = 0; i < 18; i++) begin
      mosi_c = word[17-i];
      tick();
      if (i < 17 && rx_valid_c) noise++;
      if (frame_err_c || miso_c) noise++;
    end
    tests++;
    if (rx_valid_c !== 1'b1 || rx_data_c !== word || noise != 0) begin
      fails++;
      $display("FAIL %s: got vld=%b data=%h noise=%0d want 1 %h 0", name, rx_valid_c, rx_data_c, noise, word);
    end
    mosi_c = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    ss_n_c = 1'b1; mosi_c = 1'b0; tx_valid_c = 1'b0; tx_data_c = 16'h0000;
    tick(); tick();
    tests++;
    if ({miso_a, rx_valid_a, frame_err_a, busy_a, miso_b, rx_valid_b, frame_err_b, busy_b} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ab_flags: got %b%b%b%b %b%b%b%b want all 0", miso_a, rx_valid_a, frame_err_a,
               busy_a, miso_b, rx_valid_b, frame_err_b, busy_b);
    end
    tests++;
    if (rx_data_a !== 10'h000 || rx_data_b !== 10'h000 || rx_data_c !== 18'h00000) begin
      fails++;
      $display("FAIL reset_rx_data: got %h %h %h want 0", rx_data_a, rx_data_b, rx_data_c);
    end
    tests++;
    if ({miso_c, rx_valid_c, frame_err_c, busy_c} !== 4'h0) begin
      fails++;
      $display("FAIL reset_c_flags: got %b%b%b%b want 0000", miso_c, rx_valid_c, frame_err_c, busy_c);
    end
    rst_n = 1'b1;
    held_a = 10'h000;
    held_b = 10'h000;
    tick();
  endtask

  task automatic test_write;
    frame_ab(1'b0, 10'h235, 1'b0, 10'h235, 10'h2B1, "write");
    ss_n = 1'b1; tick();
    tests++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || frame_err_a !== 1'b0 || miso_a !== 1'b0) begin
      fails++;
      $display("FAIL write_release: got busy=%b%b err=%b miso=%b want 00 0 0", busy_a, busy_b, frame_err_a, miso_a);
    end
  endtask

  task automatic test_read;
    logic [7:0] seq_a;
    logic [7:0] seq_b;
    int bad;
    seq_a = 8'b10100001;
    seq_b = 8'b10000101;
    frame_ab(1'b1, 10'h2A7, 1'b0, 10'h2A7, 10'h395, "read_addr");
    ss_n = 1'b1; tick();
    tests++;
    if (busy_a !== 1'b0) begin
      fails++;
      $display("FAIL read_addr_idle: got busy=%b want 0", busy_a);
    end
    frame_ab(1'b1, 10'h300, 1'b0, 10'h300, 10'h003, "read_data");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (miso_a || miso_b || !busy_a) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL wait_tx_hold: got %0d bad cycles want 0", bad);
    end
    tx_data = 8'hA1; tx_valid = 1'b1;
    tick();
    tx_data = 8'h5E;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      tests++;
      if (miso_a !== seq_a[7-i] || miso_b !== seq_b[7-i]) begin
        fails++;
        $display("FAIL tx_bit%0d: got a=%b b=%b want a=%b b=%b", i, miso_a, miso_b, seq_a[7-i], seq_b[7-i]);
      end
    end
    tick();
    tests++;
    if (miso_a !== 1'b0 || miso_b !== 1'b0 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL tx_end: got miso=%b%b busy=%b want 00 1", miso_a, miso_b, busy_a);
    end
    tx_valid = 1'b0;
    ss_n = 1'b1; tick();
  endtask

  task automatic test_lsb;
    frame_ab(1'b0, 10'h200, 1'b0, 10'h200, 10'h001, "lsb_rx");
    ss_n = 1'b1; tick();
  endtask

  task automatic test_abort;
    logic [3:0] bits;
    bits = 4'b1011;
    ss_n = 1'b0; mosi = 1'b0; tick();
    mosi = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      mosi = bits[3-i];
      tick();
    end
    ss_n = 1'b1; tick();
    tests++;
    if (frame_err_a !== 1'b1 || frame_err_b !== 1'b1 || rx_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL abort_pulse: got err=%b%b vld=%b busy=%b want 11 0 0", frame_err_a, frame_err_b, rx_valid_a, busy_a);
    end
    tests++;
    if (rx_data_a !== held_a || rx_data_b !== held_b) begin
      fails++;
      $display("FAIL abort_rx_hold: got %h %h want %h %h", rx_data_a, rx_data_b, held_a, held_b);
    end
    tick();
    tests++;
    if (frame_err_a !== 1'b0 || frame_err_b !== 1'b0) begin
      fails++;
      $display("FAIL abort_one_cycle: got err=%b%b want 00", frame_err_a, frame_err_b);
    end
    frame_ab(1'b0, 10'h0FF, 1'b0, 10'h0FF, 10'h3FC, "post_abort");
    ss_n = 1'b1; tick();
  endtask

  task automatic test_ss_on_completion;
    frame_ab(1'b1, 10'h155, 1'b1, 10'h155, 10'h2AA, "rise_last");
    tests++;
    if (busy_a !== 1'b0 || frame_err_a !== 1'b0 || frame_err_b !== 1'b0) begin
      fails++;
      $display("FAIL rise_last_idle: got busy=%b err=%b%b want 0 00", busy_a, frame_err_a, frame_err_b);
    end
    frame_ab(1'b1, 10'h3C3, 1'b0, 10'h3C3, 10'h30F, "pending_read");
    tx_data = 8'h81; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tests++;
    if (miso_a !== 1'b1 || miso_b !== 1'b1) begin
      fails++;
      $display("FAIL pending_latch: got miso=%b%b want 11", miso_a, miso_b);
    end
    tick(); tick();
    ss_n = 1'b1; tick();
    tests++;
    if (frame_err_a !== 1'b1 || miso_a !== 1'b0 || busy_a !== 1'b0 || frame_err_b !== 1'b1) begin
      fails++;
      $display("FAIL tx_abort: got err=%b%b miso=%b busy=%b want 11 0 0", frame_err_a, frame_err_b, miso_a, busy_a);
    end
    tick();
  endtask

  task automatic test_reset_mid_tx;
    frame_ab(1'b1, 10'h111, 1'b0, 10'h111, 10'h222, "rst_addr");
    ss_n = 1'b1; tick();
    frame_ab(1'b1, 10'h222, 1'b0, 10'h222, 10'h111, "rst_data");
    tx_data = 8'hA1; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick(); tick();
    tests++;
    if (miso_a !== 1'b1 || miso_b !== 1'b0) begin
      fails++;
      $display("FAIL rst_tx_bit2: got miso=%b%b want 10", miso_a, miso_b);
    end
    rst_n = 1'b0; ss_n = 1'b1; tick();
    tests++;
    if (miso_a !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0 || rx_data_a !== 10'h000) begin
      fails++;
      $display("FAIL rst_mid_tx: got miso=%b busy=%b%b rx=%h want 0 00 000", miso_a, busy_a, busy_b, rx_data_a);
    end
    rst_n = 1'b1; tick();
    held_a = 10'h000;
    held_b = 10'h000;
    frame_ab(1'b1, 10'h111, 1'b0, 10'h111, 10'h222, "rst_addr2");
    ss_n = 1'b1; tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    held_a = 10'h000;
    held_b = 10'h000;
    tx_data = 8'hFF; tx_valid = 1'b1;
    frame_ab(1'b1, 10'h0F0, 1'b0, 10'h0F0, 10'h03C, "after_rst");
    tests++;
    if (miso_a !== 1'b0 || miso_b !== 1'b0 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL pending_cleared: got miso=%b%b busy=%b want 00 1", miso_a, miso_b, busy_a);
    end
    tx_valid = 1'b0;
    ss_n = 1'b1; tick();
  endtask

  task automatic test_wide;
    logic [15:0] seq;
    int bad;
    seq = 16'h8001;
    bad = 0;
    frame_c(1'b0, 18'h2BEEF, "wide_write");
    ss_n_c = 1'b1; tick();
    frame_c(1'b1, 18'h00001, "wide_addr");
    ss_n_c = 1'b1; tick();
    frame_c(1'b1, 18'h3FFFF, "wide_data");
    tx_data_c = 16'h8001; tx_valid_c = 1'b1;
    tick();
    tx_valid_c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      if (miso_c !== seq[15-i]) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL wide_tx_seq: got %0d wrong bits want 0", bad);
    end
    tick();
    tests++;
    if (miso_c !== 1'b0 || busy_c !== 1'b1 || frame_err_c !== 1'b0) begin
      fails++;
      $display("FAIL wide_tx_end: got miso=%b busy=%b err=%b want 0 1 0", miso_c, busy_c, frame_err_c);
    end
    ss_n_c = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_lsb();
    test_abort();
    test_ss_on_completion();
    test_reset_mid_tx();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
